// File: rtl/gcd_pkg.sv
// Shared types and defaults for the parametrised GCD unit.
// Optional step counter is enabled by defining GCD_CYCLE_COUNT_EN.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam int GCD_WIDTH_DEF     = 16;
  localparam int GCD_CNT_WIDTH_DEF = 16;

  // Packs operands into the request message: A in the low half, B in the high half.
  function automatic logic [2*GCD_WIDTH_DEF-1:0] gcd_pack(
    input logic [GCD_WIDTH_DEF-1:0] a,
    input logic [GCD_WIDTH_DEF-1:0] b
  );
    return {b, a};
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers with compare, subtract and swap for subtract/swap Euclid.
// A step with B==0 leaves the registers unchanged; the FSM retires the result.
module gcd_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_in_i,
  input  logic [WIDTH-1:0] b_in_i,
  output logic [WIDTH-1:0] a_o,
  output logic             b_zero_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_lt_b;

  assign a_lt_b   = (a_q < b_q);
  assign b_zero_o = (b_q == '0);
  assign a_o      = a_q;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clear_i) begin
      a_d = '0;
      b_d = '0;
    end else if (load_i) begin
      a_d = a_in_i;
      b_d = b_in_i;
    end else if (step_i && !b_zero_o) begin
      if (a_lt_b) begin
        a_d = b_q;
        b_d = a_q;
      end else begin
        // Only reached with A>=B, so no borrow can occur.
        a_d = a_q - b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/gcd_unit_param.sv
// Parametrised GCD unit: valid/ready request and response, synchronous abort.
// Define GCD_CYCLE_COUNT_EN to add the saturating resp_cycles step counter.
module gcd_unit_param
  import gcd_pkg::*;
#(
  parameter int WIDTH     = GCD_WIDTH_DEF,
  parameter int CNT_WIDTH = GCD_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [2*WIDTH-1:0]   req_msg,
  input  logic                 req_val,
  output logic                 req_rdy,
  output logic [WIDTH-1:0]     resp_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
`ifdef GCD_CYCLE_COUNT_EN
  output logic [CNT_WIDTH-1:0] resp_cycles,
`endif
  output gcd_state_e           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid are decoded from state only, never from inputs.

  if (WIDTH < 2 || WIDTH > 64 || CNT_WIDTH < 1) begin : g_bad_param
    $error("gcd_unit_param: WIDTH must be 2..64 and CNT_WIDTH >= 1");
  end

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] resp_msg_q, resp_msg_d;
  logic [WIDTH-1:0] a_val;
  logic             b_zero;
  logic             load, step;

  assign load = (state_q == IDLE) && req_val && !clear;
  assign step = (state_q == CALC) && !clear;

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (clear),
    .load_i   (load),
    .step_i   (step),
    .a_in_i   (req_msg[WIDTH-1:0]),
    .b_in_i   (req_msg[2*WIDTH-1:WIDTH]),
    .a_o      (a_val),
    .b_zero_o (b_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      resp_msg_q <= '0;
    end else begin
      state_q    <= state_d;
      resp_msg_q <= resp_msg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_msg_d = resp_msg_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (req_val) state_d = CALC;
        CALC: if (b_zero) begin
          state_d    = DONE;
          resp_msg_d = a_val;
        end
        DONE: if (resp_rdy) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_rdy   = (state_q == IDLE);
    resp_val  = (state_q == DONE);
    resp_msg  = resp_msg_q;
    dbg_state = state_q;
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Counts every CALC edge, including the retiring one; sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear || load) begin
      count_d = '0;
    end else if (state_q == CALC && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign resp_cycles = count_q;
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// Directed plus random bench for gcd_unit_param (32-bit and default 16-bit instances).
// Step-count checks on resp_cycles are compiled in when GCD_CYCLE_COUNT_EN is defined.
module tb_gcd_unit_param;
  import gcd_pkg::*;

  localparam int W      = 32;
  localparam int CW     = 16;
  localparam int BUDGET = 5000;

  logic             clk = 1'b0;
  logic             reset_n, clear, req_val, resp_rdy;
  logic [2*W-1:0]   req_msg;
  logic             req_rdy, resp_val;
  logic [W-1:0]     resp_msg;
  gcd_state_e       dbg_state;
  logic [31:0]      req_msg16;
  logic             req_rdy16, resp_val16;
  logic [15:0]      resp_msg16;
  gcd_state_e       dbg_state16;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CW-1:0]    resp_cycles, resp_cycles16;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  assign req_msg16 = gcd_pack(req_msg[15:0], req_msg[W+15:W]);

  gcd_unit_param #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
`ifdef GCD_CYCLE_COUNT_EN
    .resp_cycles(resp_cycles),
`endif
    .dbg_state(dbg_state)
  );

  gcd_unit_param dut16 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .req_msg(req_msg16), .req_val(req_val), .req_rdy(req_rdy16),
    .resp_msg(resp_msg16), .resp_val(resp_val16), .resp_rdy(resp_rdy),
`ifdef GCD_CYCLE_COUNT_EN
    .resp_cycles(resp_cycles16),
`endif
    .dbg_state(dbg_state16)
  );

  // Reference: result by modulo Euclid, step count from the subtract/swap rule.
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int ref_steps(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    int s = 0;
    while (b != 0) begin
      if (a < b) begin
        t = a; a = b; b = t;
      end else begin
        a = a - b;
      end
      s++;
    end
    return s + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the acceptance edge; waits, checks, holds, then consumes.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    int edges = 0;
    int s, s16;
    logic [W-1:0] exp_g, held;
    s = ref_steps(a, b);
    s16 = ref_steps(a[15:0], b[15:0]);
    exp_q.push_back(W'(ref_gcd(a, b)));
    while (!resp_val && edges < BUDGET) begin
      tick();
      edges++;
    end
    check({tag, ".lat"}, edges, s);
    if (!resp_val) return;
    exp_g = exp_q.pop_front();
    check({tag, ".msg"}, resp_msg, exp_g);
`ifdef GCD_CYCLE_COUNT_EN
    check({tag, ".cyc"}, resp_cycles, (s > 2**CW-1) ? 2**CW-1 : s);
`endif
    if (s16 <= s) begin
      check({tag, ".val16"}, resp_val16, 1'b1);
      check({tag, ".msg16"}, resp_msg16, ref_gcd(a[15:0], b[15:0]));
    end
    held = resp_msg;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_val"}, resp_val, 1'b1);
      check({tag, ".hold_msg"}, resp_msg, held);
      check({tag, ".hold_rdy"}, req_rdy, 1'b0);
    end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    check({tag, ".post_val"}, resp_val, 1'b0);
    check({tag, ".post_rdy"}, req_rdy, 1'b1);
    check({tag, ".post_msg"}, resp_msg, held);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    check({tag, ".idle"}, req_rdy, 1'b1);
    req_msg = {b, a};
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    collect(a, b, hold, tag);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    reset_n = 1'b0; clear = 1'b0; req_val = 1'b0; resp_rdy = 1'b0; req_msg = '0;
    #1;
    check("rst.req_rdy", req_rdy, 1'b1);
    check("rst.resp_val", resp_val, 1'b0);
    check("rst.resp_msg", resp_msg, 0);
    check("rst.state", dbg_state, IDLE);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    run(5, 10, 4, "t1");
    run(15, 150, 0, "t2");
    run(0, 0, 1, "t3a");
    run(7, 0, 0, "t3b");
    run(0, 9, 2, "t3c");
    run(196608, 131072, 0, "t4");
    check("t4.const", resp_msg, 65536);

    // Abort mid-CALC: response must never appear, last result kept.
    req_msg = {W'(150), W'(15)};
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.state", dbg_state, IDLE);
    check("clr.req_rdy", req_rdy, 1'b1);
    check("clr.resp_msg", resp_msg, 65536);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (resp_val) seen++;
    end
    check("clr.no_resp", seen, 0);
    run(5, 10, 0, "clr.after");

    // clear together with req_val in IDLE blocks acceptance.
    req_msg = {W'(6), W'(3)};
    req_val = 1'b1;
    clear = 1'b1;
    tick();
    req_val = 1'b0;
    clear = 1'b0;
    check("clrreq.state", dbg_state, IDLE);
    tick();
    check("clrreq.state2", dbg_state, IDLE);

    // Abort while a response is pending.
    req_msg = {W'(12), W'(8)};
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    seen = 0;
    while (!resp_val && seen < BUDGET) begin
      tick();
      seen++;
    end
    check("clrdone.msg", resp_msg, 4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrdone.val", resp_val, 1'b0);
    check("clrdone.keep", resp_msg, 4);

    // Asynchronous reset mid-CALC.
    req_msg = {W'(150), W'(15)};
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("arst.resp_msg", resp_msg, 0);
    check("arst.resp_val", resp_val, 1'b0);
    check("arst.req_rdy", req_rdy, 1'b1);
    check("arst.state", dbg_state, IDLE);
    tick();
    reset_n = 1'b1;
    tick();
    run(5, 10, 0, "arst.after");

    // req_val held high: one acceptance per IDLE visit.
    req_msg = {W'(10), W'(5)};
    req_val = 1'b1;
    tick();
    collect(5, 10, 3, "hold1");
    req_msg = {W'(18), W'(12)};
    tick();
    req_val = 1'b0;
    collect(12, 18, 1, "hold2");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 1023));
      rb = W'($urandom_range(0, 1023));
      run(ra, rb, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    check("end.queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
